// File: rtl/cs_window_avg.sv
// Sliding-window average over the last N samples: finds Xappr (largest sample <= floor(sum/N))
// and outputs floor((sum + N*Xappr)/(N-1)) or plain floor(sum/N); latency N+1 cycles from accept.
// Backpressure: in_ready is high only in IDLE; samples offered during SCAN/CALC are not taken.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_valid/in_ready input handshake; X (W bits) is the sample, mode (0 approx, 1 plain) rides with it
//   out_valid, Y      one-cycle result pulse; Y (W+2 bits) holds until the next pulse
//   win_full          high once N samples have been accepted since reset
module cs_window_avg #(
    parameter int W = 8,
    parameter int N = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   X,
    input  logic           mode,
    output logic           out_valid,
    output logic [W+1:0]   Y,
    output logic           win_full
);

    localparam int SW = W + $clog2(N);     // running-sum width, holds N*(2^W-1)
    localparam int CW = $clog2(N + 1);     // fill count 0..N
    localparam int IW = $clog2(N);         // scan index 0..N-1
    localparam int SH = $clog2(N - 1);     // N-1 is a power of two, so /(N-1) is a shift
    localparam int YW = W + 2;

    typedef enum logic [1:0] {IDLE, SCAN, CALC} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    win [N];
    logic [SW-1:0]   sum;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [IW-1:0]   idx;
    logic [W-1:0]    best;
    logic            mode_q;
    logic            accept;
    logic [W-1:0]    scan_e;
    logic            scan_qual;
    logic [SW-1:0]   best_times_n;
    logic [SW:0]     approx_full;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid & in_ready;
    assign win_full  = (count == CW'(N));
    assign count_nxt = (count == CW'(N)) ? count : count + CW'(1);

    // e <= floor(sum/N) is equivalent to e*N <= sum, which avoids a divider in the scan.
    assign scan_e       = win[idx];
    assign scan_qual    = (SW'(scan_e) * SW'(N)) <= sum;
    assign best_times_n = SW'(best) * SW'(N);
    // One extra bit: sum + N*best can reach 2*N*(2^W-1).
    assign approx_full  = {1'b0, sum} + {1'b0, best_times_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && (count_nxt == CW'(N))) state_nxt = SCAN;
            SCAN: if (idx == IW'(N - 1)) state_nxt = CALC;
            CALC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                win[i] <= '0;
            end
            sum       <= '0;
            count     <= '0;
            idx       <= '0;
            best      <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            Y         <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = N - 1; i > 0; i--) begin
                            win[i] <= win[i-1];
                        end
                        win[0] <= X;
                        // Intermediate may wrap; the final sum always fits SW bits.
                        sum    <= sum + SW'(X) - SW'(win[N-1]);
                        count  <= count_nxt;
                        mode_q <= mode;
                        idx    <= '0;
                        best   <= '0;   // a fresh window needs a fresh maximum
                    end
                end
                SCAN: begin
                    if (scan_qual && (scan_e > best)) begin
                        best <= scan_e;
                    end
                    idx <= idx + IW'(1);
                end
                CALC: begin
                    Y         <= mode_q ? YW'(sum / SW'(N)) : YW'(approx_full >> SH);
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_window_avg.sv
// Testbench for cs_window_avg (W=8, N=9): scenario tasks drive samples, a queue holds expected Y
// values pushed at acceptance, and a negedge monitor pops and compares on every out_valid.
module tb_cs_window_avg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] X = '0;
    logic       mode = 1'b0;
    logic       out_valid;
    logic [9:0] Y;
    logic       win_full;

    int checks = 0;
    int errors = 0;
    int expq[$];
    int mwin[9];
    int mcount = 0;

    cs_window_avg #(.W(8), .N(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .mode      (mode),
        .out_valid (out_valid),
        .Y         (Y),
        .win_full  (win_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard side: every result pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            int e;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: Y=%0d, no result expected", Y);
            end else begin
                e = expq.pop_front();
                if (Y !== 10'(e)) begin
                    errors++;
                    $display("FAIL result_Y: got %0d, expected %0d", Y, e);
                end
            end
        end
    end

    function automatic int model_y(input logic m);
        int s, b;
        s = 0;
        b = 0;
        for (int i = 0; i < 9; i++) s += mwin[i];
        for (int i = 0; i < 9; i++) if ((mwin[i] * 9 <= s) && (mwin[i] > b)) b = mwin[i];
        return m ? (s / 9) : ((s + 9 * b) / 8);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) mwin[i] = 0;
        mcount = 0;
        expq.delete();
    endtask

    // exp < 0 means take the expected value from the reference model.
    task automatic model_accept(input int x, input logic m, input int exp);
        for (int i = 8; i > 0; i--) mwin[i] = mwin[i-1];
        mwin[0] = x;
        if (mcount < 9) mcount++;
        if (mcount == 9) expq.push_back((exp >= 0) ? exp : model_y(m));
    endtask

    // Called and returns at a negedge.
    task automatic send(input int x, input logic m, input int exp);
        int n;
        logic [31:0] xv;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_ready_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
        end
        xv = x;
        in_valid = 1'b1;
        X = xv[7:0];
        mode = m;
        @(posedge clk);
        model_accept(x, m, exp);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d in_ready=%0b, expected 0 pending and ready", expq.size(), in_ready);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
        checks++; if (Y !== 10'd0) begin errors++; $display("FAIL reset_Y: got %0d, expected 0", Y); end
        checks++; if (win_full !== 1'b0) begin errors++; $display("FAIL reset_win_full: got %0b, expected 0", win_full); end
    endtask

    task automatic test_fill();
        int n;
        do_reset();
        for (int v = 1; v <= 8; v++) send(v, 1'b0, -1);
        checks++; if (win_full !== 1'b0) begin errors++; $display("FAIL fill8_win_full: got %0b, expected 0", win_full); end
        send(9, 1'b0, 11);
        checks++; if (win_full !== 1'b1) begin errors++; $display("FAIL fill9_win_full: got %0b, expected 1", win_full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %0b, expected 0", in_ready); end
        wait_out(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL latency: got %0d cycles, expected 10", n); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: out_valid=%0b, expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_calc: got %0b, expected 1", in_ready); end
        wait_drain();
    endtask

    task automatic test_slide();
        int n;
        // Window 2..10, plain mode.
        send(10, 1'b1, 6);
        wait_out(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL slide_latency: got %0d cycles, expected 10", n); end
        wait_drain();
        // Same window 2..10, approx mode.
        do_reset();
        for (int v = 1; v <= 9; v++) send(v, 1'b0, 11);
        wait_drain();
        send(10, 1'b0, 13);
        wait_drain();
    endtask

    task automatic test_zeros();
        do_reset();
        for (int i = 0; i < 8; i++) send(0, 1'b0, -1);
        send(100, 1'b0, 12);
        wait_drain();
    endtask

    task automatic test_max();
        do_reset();
        for (int i = 0; i < 8; i++) send(255, 1'b0, -1);
        send(255, 1'b0, 573);
        wait_drain();
        send(255, 1'b1, 255);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int acc, last, t;
        logic rdy;
        logic [7:0] xv;
        logic mv;
        do_reset();
        acc = 0; last = 0; t = 0;
        xv = 8'($urandom_range(0, 255));
        mv = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        X = xv;
        mode = mv;
        while (acc < 30 && t < 800) begin
            rdy = in_ready;
            @(posedge clk);
            t++;
            if (rdy) begin
                model_accept(int'(xv), mv, -1);
                acc++;
                if (acc >= 10) begin
                    checks++;
                    if (t - last !== 11) begin
                        errors++;
                        $display("FAIL hold_spacing: accept %0d after %0d cycles, expected 11", acc, t - last);
                    end
                end
                last = t;
            end
            @(negedge clk);
            if (rdy) begin
                xv = 8'($urandom_range(0, 255));
                mv = 1'($urandom_range(0, 1));
                X = xv;
                mode = mv;
            end
        end
        in_valid = 1'b0;
        checks++; if (acc !== 30) begin errors++; $display("FAIL hold_accepts: got %0d, expected 30", acc); end
        wait_drain();
    endtask

    task automatic test_reset_mid_scan();
        int n;
        do_reset();
        for (int v = 1; v <= 8; v++) send(v, 1'b0, -1);
        send(9, 1'b0, 11);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %0b, expected 1", in_ready); end
        checks++; if (Y !== 10'd0) begin errors++; $display("FAIL abort_Y: got %0d, expected 0", Y); end
        checks++; if (win_full !== 1'b0) begin errors++; $display("FAIL abort_win_full: got %0b, expected 0", win_full); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %0b, expected 0", out_valid); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_output: out_valid=%0b at cycle %0d, expected 0", out_valid, i); end
        end
        for (int v = 1; v <= 9; v++) send(v, 1'b0, 11);
        wait_out(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL refill_latency: got %0d cycles, expected 10", n); end
        wait_drain();
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        test_reset();
        test_fill();
        test_slide();
        test_zeros();
        test_max();
        test_back_to_back();
        test_reset_mid_scan();
        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
